// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use, taken branch, multi-cycle EX ops.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_controller #(
    parameter int REG_W      = 3,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic             Branch_Taken,
    input  logic             MC_Start,
    output logic             PC_Enable,
    output logic             IF_ID_Enable,
    output logic             IF_ID_CLR,
    output logic             ID_EX_Enable,
    output logic             ID_EX_CLR,
    output logic             EX_MEM_CLR,
    output logic             MC_Busy,
    output logic [15:0]      Stall_Cycles,
    output logic [15:0]      Flush_Count
);

    if (MC_LATENCY < 2 || MC_LATENCY > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("MC_LATENCY out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             do_flush;
    logic             do_freeze;
    logic             do_stall;

    // Hazard decode; a held MC op in EX masks branch and MC_Start
    always_comb begin
        load_use  = EX_MemRead && (EX_Rt != '0) &&
                    ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
        do_flush  = (state_q == RUN) && Branch_Taken;
        do_freeze = ((state_q == RUN) && !Branch_Taken && MC_Start) ||
                    ((state_q == MC_BUSY) && (cnt_q > CNT_ONE));
        do_stall  = load_use && !do_flush && !do_freeze;
    end

    // State register and multi-cycle down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: enter MC_BUSY on accepted start, leave after count expires
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (MC_Start && !Branch_Taken) begin
                    state_d = MC_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            MC_BUSY: begin
                if (cnt_q > CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Pipeline register controls; reset fills the pipe with NOPs
    always_comb begin
        PC_Enable    = 1'b1;
        IF_ID_Enable = 1'b1;
        IF_ID_CLR    = 1'b0;
        ID_EX_Enable = 1'b1;
        ID_EX_CLR    = 1'b0;
        EX_MEM_CLR   = 1'b0;
        MC_Busy      = (state_q == MC_BUSY);
        if (!rst_n) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            IF_ID_CLR    = 1'b1;
            ID_EX_CLR    = 1'b1;
            EX_MEM_CLR   = 1'b1;
            MC_Busy      = 1'b0;
        end else begin
            unique case (1'b1)
                do_flush: begin
                    IF_ID_CLR = 1'b1;
                    ID_EX_CLR = 1'b1;
                end
                do_freeze: begin
                    PC_Enable    = 1'b0;
                    IF_ID_Enable = 1'b0;
                    ID_EX_Enable = 1'b0;
                    EX_MEM_CLR   = 1'b1;
                end
                do_stall: begin
                    PC_Enable    = 1'b0;
                    IF_ID_Enable = 1'b0;
                    ID_EX_CLR    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Saturating stall-cycle and taken-flush counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_Enable && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (do_flush && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign Stall_Cycles = stall_q;
    assign Flush_Count  = flush_q;
`else
    assign Stall_Cycles = '0;
    assign Flush_Count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed cases plus
// randomized traffic against a cycle-age reference model.
module tb_pipeline_hazard_controller;

    localparam int REG_W      = 3;
    localparam int MC_LATENCY = 4;
    localparam int CNT_W      = 4;

    // {PC_En, IFID_En, IFID_CLR, IDEX_En, IDEX_CLR, EXMEM_CLR, MC_Busy}
    localparam logic [6:0] V_RST   = 7'b0011110;
    localparam logic [6:0] V_DEF   = 7'b1101000;
    localparam logic [6:0] V_FLUSH = 7'b1111100;
    localparam logic [6:0] V_FRZ   = 7'b0000010;
    localparam logic [6:0] V_STALL = 7'b0001100;
    localparam logic [6:0] V_BUSY  = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rt;
    logic             ID_UsesRt, EX_MemRead;
    logic             Branch_Taken, MC_Start;
    logic             PC_Enable, IF_ID_Enable, IF_ID_CLR;
    logic             ID_EX_Enable, ID_EX_CLR, EX_MEM_CLR, MC_Busy;
    logic [15:0]      Stall_Cycles, Flush_Count;
    logic [6:0]       dv;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: cycles since the MC op entered MC_BUSY (-1 idle)
    int mc_age    = -1;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign dv = {PC_Enable, IF_ID_Enable, IF_ID_CLR, ID_EX_Enable,
                 ID_EX_CLR, EX_MEM_CLR, MC_Busy};

    pipeline_hazard_controller #(
        .REG_W(REG_W), .MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
        .Branch_Taken(Branch_Taken), .MC_Start(MC_Start),
        .PC_Enable(PC_Enable), .IF_ID_Enable(IF_ID_Enable),
        .IF_ID_CLR(IF_ID_CLR), .ID_EX_Enable(ID_EX_Enable),
        .ID_EX_CLR(ID_EX_CLR), .EX_MEM_CLR(EX_MEM_CLR),
        .MC_Busy(MC_Busy), .Stall_Cycles(Stall_Cycles),
        .Flush_Count(Flush_Count)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_out(
        input logic r, input logic [2:0] rs, input logic [2:0] rt,
        input logic u, input logic mr, input logic [2:0] ert,
        input logic br, input logic mc);
        logic lu;
        logic [6:0] v;
        lu = mr && (ert != 0) && (ert == rs || (u && ert == rt));
        if (!r) return V_RST;
        if (mc_age < 0) begin
            if (br)      v = V_FLUSH;
            else if (mc) v = V_FRZ;
            else if (lu) v = V_STALL;
            else         v = V_DEF;
        end else if (mc_age < MC_LATENCY - 1) begin
            v = V_FRZ | V_BUSY;
        end else begin
            v = (lu ? V_STALL : V_DEF) | V_BUSY;
        end
        return v;
    endfunction

    task automatic step(input logic r, input logic [2:0] rs,
                        input logic [2:0] rt, input logic u,
                        input logic mr, input logic [2:0] ert,
                        input logic br, input logic mc,
                        input string tag, output logic [6:0] obs);
        logic [6:0] e;
        @(negedge clk);
        rst_n = r; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = u;
        EX_MemRead = mr; EX_Rt = ert; Branch_Taken = br; MC_Start = mc;
        #1;
        if (!r) begin
            exp_stall = 0;
            exp_flush = 0;
        end
        e = model_out(r, rs, rt, u, mr, ert, br, mc);
        obs = dv;
        check(tag, {9'd0, dv}, {9'd0, e});
`ifdef HAZARD_PERF_EN
        check({tag, "_stall"}, Stall_Cycles, 16'(exp_stall));
        check({tag, "_flush"}, Flush_Count, 16'(exp_flush));
`else
        check({tag, "_perf0"}, Stall_Cycles | Flush_Count, 16'd0);
`endif
        @(posedge clk);
        if (!r) begin
            mc_age = -1;
        end else begin
            if (!e[6] && exp_stall < 65535) exp_stall++;
            if (mc_age < 0) begin
                if (br) begin
                    if (exp_flush < 65535) exp_flush++;
                end else if (mc) begin
                    mc_age = 1;
                end
            end else if (mc_age == MC_LATENCY - 1) begin
                mc_age = -1;
            end else begin
                mc_age++;
            end
        end
    endtask

    task automatic idle(input string tag, output logic [6:0] obs);
        step(1, 0, 0, 0, 0, 0, 0, 0, tag, obs);
    endtask

    initial begin
        logic [6:0] v;
        logic [2:0] rs, rt, ert;
        logic       br, mc, r;
        rst_n = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
        EX_MemRead = 1'b0; EX_Rt = '0; Branch_Taken = 1'b0;
        MC_Start = 1'b0;

        step(0, 0, 0, 0, 0, 0, 0, 0, "rst", v);
        check("rst_vec", {9'd0, v}, {9'd0, V_RST});
        idle("def", v);
        check("def_vec", {9'd0, v}, {9'd0, V_DEF});

        step(1, 3, 0, 0, 1, 3, 0, 0, "lu_rs", v);
        check("lu_rs_vec", {9'd0, v}, {9'd0, V_STALL});
        idle("lu_after", v);
        step(1, 0, 0, 0, 1, 0, 0, 0, "lu_r0", v);
        check("lu_r0_vec", {9'd0, v}, {9'd0, V_DEF});
        step(1, 1, 3, 0, 1, 3, 0, 0, "lu_nort", v);
        check("lu_nort_vec", {9'd0, v}, {9'd0, V_DEF});
        step(1, 1, 3, 1, 1, 3, 0, 0, "lu_rt", v);
        check("lu_rt_vec", {9'd0, v}, {9'd0, V_STALL});

        step(1, 0, 0, 0, 0, 0, 1, 0, "br", v);
        check("br_vec", {9'd0, v}, {9'd0, V_FLUSH});
        step(1, 3, 0, 0, 1, 3, 1, 0, "br_lu", v);
        check("br_lu_vec", {9'd0, v}, {9'd0, V_FLUSH});
        step(1, 0, 0, 0, 0, 0, 1, 1, "br_mc", v);
        check("br_mc_vec", {9'd0, v}, {9'd0, V_FLUSH});

        step(1, 0, 0, 0, 0, 0, 0, 1, "mc0", v);
        check("mc0_vec", {9'd0, v}, {9'd0, V_FRZ});
        idle("mc1", v);
        check("mc1_vec", {9'd0, v}, {9'd0, V_FRZ | V_BUSY});
        step(1, 3, 0, 0, 1, 3, 1, 1, "mc2_ign", v);
        check("mc2_vec", {9'd0, v}, {9'd0, V_FRZ | V_BUSY});
        idle("mc_rel", v);
        check("mc_rel_vec", {9'd0, v}, {9'd0, V_DEF | V_BUSY});
        idle("mc_done", v);
        check("mc_done_vec", {9'd0, v}, {9'd0, V_DEF});

        step(1, 0, 0, 0, 0, 0, 0, 1, "ov0", v);
        idle("ov1", v);
        idle("ov2", v);
        step(1, 5, 0, 0, 1, 5, 0, 0, "ov_rel", v);
        check("ov_rel_vec", {9'd0, v}, {9'd0, V_STALL | V_BUSY});
        idle("ov_after", v);
        check("ov_after_vec", {9'd0, v}, {9'd0, V_DEF});

        step(1, 0, 0, 0, 0, 0, 0, 1, "rb0", v);
        idle("rb1", v);
        step(0, 0, 0, 0, 0, 0, 0, 0, "rb_rst", v);
        check("rb_rst_vec", {9'd0, v}, {9'd0, V_RST});
        idle("rb_rel", v);
        check("rb_rel_vec", {9'd0, v}, {9'd0, V_DEF});
        idle("rb_rel2", v);

        step(1, 2, 0, 0, 1, 2, 0, 0, "pf_lu1", v);
        idle("pf_i1", v);
        step(1, 2, 0, 0, 1, 2, 0, 0, "pf_lu2", v);
        idle("pf_i2", v);
        step(1, 4, 0, 0, 1, 4, 0, 0, "pf_lu3", v);
        step(1, 0, 0, 0, 0, 0, 1, 0, "pf_br1", v);
        idle("pf_i3", v);
        step(1, 0, 0, 0, 0, 0, 1, 0, "pf_br2", v);
        @(negedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        check("perf_stall3", Stall_Cycles, 16'd3);
        check("perf_flush2", Flush_Count, 16'd2);
`else
        check("perf_off_stall", Stall_Cycles, 16'd0);
        check("perf_off_flush", Flush_Count, 16'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            ert = 3'($urandom_range(0, 7));
            rs  = ($urandom_range(0, 1) != 0) ? ert : 3'($urandom_range(0, 7));
            rt  = ($urandom_range(0, 1) != 0) ? ert : 3'($urandom_range(0, 7));
            br  = (mc_age < 0) && ($urandom_range(0, 7) == 0);
            mc  = (mc_age < 0) && ($urandom_range(0, 9) == 0);
            step(r, rs, rt, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ert, br, mc, "rnd", v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
